// File: rtl/ppu_compressor_pkg.sv
// Shared PPU definitions: pooled-output packet and the sparse
// (value, zero-run index) packet consumed by the next layer buffer.
`ifndef POOLING_OUT_SIZE
`define POOLING_OUT_SIZE 8
`endif
`ifndef Accumulator_buffer_k_offset
`define Accumulator_buffer_k_offset 16
`endif
`ifndef IDX_WIDTH
`define IDX_WIDTH 4
`endif
`ifndef PPU_FIFO_DEPTH
`define PPU_FIFO_DEPTH 8
`endif

package ppu_compressor_pkg;

    localparam int POOL_LANES = `POOLING_OUT_SIZE;
    localparam int PPU_DATA_W = 16;
    localparam int PPU_IDX_W  = `IDX_WIDTH;
    localparam int PPU_K_W    = $clog2(`Accumulator_buffer_k_offset);
    localparam int PPU_CNT_W  = $clog2(POOL_LANES + 1);

    typedef struct packed {
        logic [POOL_LANES-1:0]                 valid;
        logic [POOL_LANES-1:0][PPU_DATA_W-1:0] data;
    } PPU_compress_PACKET;

    typedef struct packed {
        logic [POOL_LANES-1:0][PPU_DATA_W-1:0] data;
        logic [POOL_LANES-1:0][PPU_IDX_W-1:0]  index;
        logic [PPU_CNT_W-1:0]                  count;
        logic [PPU_K_W-1:0]                    k;
        logic                                  last;
    } PPU_SPARSE_PACKET;

endpackage

// File: rtl/ppu_sparse_fifo.sv
// Synchronous FIFO for packed sparse words; head reads as zero
// whenever the queue is empty.
module ppu_sparse_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   used;
    logic          do_push;
    logic          do_pop;

    assign full    = (used == (AW+1)'(DEPTH));
    assign empty   = (used == '0);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            used   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   used <= used + (AW+1)'(1);
                2'b01:   used <= used - (AW+1)'(1);
                default: used <= used;
            endcase
        end
    end

endmodule

// File: rtl/ppu_compressor.sv
// Drops zero activations and packs survivors into left-justified
// (value, zero-run) words queued towards the writeback path.
module ppu_compressor
    import ppu_compressor_pkg::*;
#(
    parameter int LANES      = `POOLING_OUT_SIZE,
    parameter int DATA_W     = 16,
    parameter int IDX_W      = `IDX_WIDTH,
    parameter int FIFO_DEPTH = `PPU_FIFO_DEPTH,
    parameter int K_W        = $clog2(`Accumulator_buffer_k_offset)
) (
    input  logic               clk,
    input  logic               rst,
    input  PPU_compress_PACKET pooling_compress_in,
    input  logic [K_W-1:0]     kc_num,
    input  logic               PPU_finish_en,
    output PPU_SPARSE_PACKET   comp_out,
    output logic               comp_valid,
    input  logic               comp_ready,
    output logic               overflow
);

    localparam int SLOT_W = $clog2(LANES);
    localparam int CNT_W  = $clog2(LANES + 1);

    logic [IDX_W-1:0] run_q;
    logic [IDX_W-1:0] run_d;
    logic [K_W-1:0]   kc_prev;
    logic             finish_q;
    logic             finish_rise;
    logic [CNT_W-1:0] cnt;
    PPU_SPARSE_PACKET word;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;

    assign finish_rise = PPU_finish_en && !finish_q;

    always_comb begin
        word      = '0;
        word.k    = kc_num;
        word.last = finish_rise;
        cnt       = '0;
        // Runs never span output channels.
        run_d     = (kc_num != kc_prev) ? '0 : run_q;
        for (int j = 0; j < LANES; j++) begin
            if (pooling_compress_in.valid[j]) begin
                if (pooling_compress_in.data[j] != '0) begin
                    word.data[cnt[SLOT_W-1:0]]  = pooling_compress_in.data[j];
                    word.index[cnt[SLOT_W-1:0]] = run_d;
                    cnt   = cnt + CNT_W'(1);
                    run_d = '0;
                end else if (run_d == '1) begin
                    word.index[cnt[SLOT_W-1:0]] = run_d;
                    cnt   = cnt + CNT_W'(1);
                    run_d = '0;
                end else begin
                    run_d = run_d + IDX_W'(1);
                end
            end
        end
        word.count = cnt;
    end

    assign push       = finish_rise || (cnt != '0);
    assign pop        = comp_valid && comp_ready;
    assign comp_valid = !empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_q    <= '0;
            kc_prev  <= '0;
            finish_q <= 1'b0;
            overflow <= 1'b0;
        end else begin
            run_q    <= finish_rise ? '0 : run_d;
            kc_prev  <= finish_rise ? '0 : kc_num;
            finish_q <= PPU_finish_en;
            if (push && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    ppu_sparse_fifo #(
        .W     ($bits(PPU_SPARSE_PACKET)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (word),
        .pop   (pop),
        .dout  (comp_out),
        .full  (full),
        .empty (empty)
    );

endmodule
